// File: rtl/baccarat_round_fsm.sv
// -----------------------------------------------------------------------------
// baccarat_round_fsm
//
// Control state machine for one Baccarat round. It walks the deal sequence
// (player card 1, banker card 1, player card 2, banker card 2), applies the
// natural / player-draw / banker-draw tableau rules to the scores fed back
// from the scoring stages, optionally deals third cards, and finally registers
// the win lights.
//
// Optional feature (compile-time macro BACCARAT_AUTO_RESTART_EN):
//   defined   - DONE dwells HOLD_CYCLES edges, then CLR pulses clear_cards for
//               one cycle, clears the lights and deals a fresh round from P1.
//   undefined - DONE holds until reset; clear_cards is tied to 0.
//
// Ports:
//   slow_clock        round clock, one FSM step per rising edge
//   resetb            asynchronous active-low reset
//   pscore, dscore    player / banker hand scores (0-9) from the scoring stages
//   pcard3            raw player third-card register value (0-13)
//   load_pcard1..3    load enables for the player card registers
//   load_dcard1..3    load enables for the banker card registers
//   clear_cards       one-cycle clear of all six card registers (auto restart)
//   player_win_light  player won, or tie (registered)
//   dealer_win_light  banker won, or tie (registered)
// -----------------------------------------------------------------------------
module baccarat_round_fsm #(
  parameter int NATURAL_MIN  = 8,
  parameter int PLAYER_STAND = 6,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clear_cards,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  localparam logic [3:0] NAT_MIN_4   = 4'(NATURAL_MIN);
  localparam logic [3:0] P_STAND_4   = 4'(PLAYER_STAND);

`ifdef BACCARAT_AUTO_RESTART_EN
  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_BCHK, S_D3,
    S_RESULT, S_DONE, S_CLR
  } state_t;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_BCHK, S_D3,
    S_RESULT, S_DONE
  } state_t;
`endif

  state_t state, state_n;

  // Banker third-card tableau, used only once the player has drawn.
  // Face cards (10-13) count as 0.
  function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] c);
    logic [3:0] v;
    v = (c >= 4'd10) ? 4'd0 : c;
    case (d)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (v != 4'd8);
      4'd4:             banker_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             banker_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             banker_draws = (v >= 4'd6) && (v <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  endfunction

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state)
      S_IDLE: state_n = S_P1;
      S_P1: begin load_pcard1 = 1'b1; state_n = S_D1; end
      S_D1: begin load_dcard1 = 1'b1; state_n = S_P2; end
      S_P2: begin load_pcard2 = 1'b1; state_n = S_D2; end
      S_D2: begin load_dcard2 = 1'b1; state_n = S_CHK; end
      S_CHK: begin
        if ((pscore >= NAT_MIN_4) || (dscore >= NAT_MIN_4)) state_n = S_RESULT;
        else if (pscore < P_STAND_4)                        state_n = S_P3;
        // Player stands: banker follows the simple draw-on-0..5 rule.
        else if (dscore <= 4'd5)                            state_n = S_D3;
        else                                                state_n = S_RESULT;
      end
      S_P3: begin load_pcard3 = 1'b1; state_n = S_BCHK; end
      // pcard3 has been captured on the edge leaving P3, so it is valid here.
      S_BCHK: state_n = banker_draws(dscore, pcard3) ? S_D3 : S_RESULT;
      S_D3: begin load_dcard3 = 1'b1; state_n = S_RESULT; end
      S_RESULT: state_n = S_DONE;
`ifdef BACCARAT_AUTO_RESTART_EN
      S_DONE: if (hold_cnt == HOLD_LAST) state_n = S_CLR;
      S_CLR:  state_n = S_P1;
`else
      S_DONE: state_n = S_DONE;
`endif
      default: state_n = S_IDLE;
    endcase
  end

`ifdef BACCARAT_AUTO_RESTART_EN
  // Counter sits at 0 outside DONE, so every DONE entry starts from 0.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)              hold_cnt <= '0;
    else if (state != S_DONE) hold_cnt <= '0;
    else                      hold_cnt <= hold_cnt + 1'b1;
  end

  assign clear_cards = (state == S_CLR);
`else
  assign clear_cards = 1'b0;
`endif

  // A tie lights both, which falls out of the two >= compares.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else if (state == S_RESULT) begin
      player_win_light <= (pscore >= dscore);
      dealer_win_light <= (dscore >= pscore);
    end
`ifdef BACCARAT_AUTO_RESTART_EN
    else if (state == S_CLR) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// -----------------------------------------------------------------------------
// tb_baccarat_round_fsm
//
// Directed bench for baccarat_round_fsm. The bench plays the scoring stages:
// it presents the four-card scores before CHK and switches to the final
// scores once the third cards have been loaded. Expected load sequences,
// latencies and lights are hand-computed per round.
// -----------------------------------------------------------------------------
module tb_baccarat_round_fsm;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] pscore     = 4'd0;
  logic [3:0] dscore     = 4'd0;
  logic [3:0] pcard3     = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       clear_cards;
  logic       player_win_light, dealer_win_light;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [5:0] L_P1 = 6'b100000;
  localparam logic [5:0] L_D1 = 6'b010000;
  localparam logic [5:0] L_P2 = 6'b001000;
  localparam logic [5:0] L_D2 = 6'b000100;
  localparam logic [5:0] L_P3 = 6'b000010;
  localparam logic [5:0] L_D3 = 6'b000001;

  baccarat_round_fsm #(
    .NATURAL_MIN (8),
    .PLAYER_STAND(6),
    .HOLD_CYCLES (4)
  ) dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .pscore          (pscore),
    .dscore          (dscore),
    .pcard3          (pcard3),
    .load_pcard1     (load_pcard1),
    .load_pcard2     (load_pcard2),
    .load_pcard3     (load_pcard3),
    .load_dcard1     (load_dcard1),
    .load_dcard2     (load_dcard2),
    .load_dcard3     (load_dcard3),
    .clear_cards     (clear_cards),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light)
  );

  always #5 slow_clock = ~slow_clock;

  wire [5:0] loads  = {load_pcard1, load_dcard1, load_pcard2,
                       load_dcard2, load_pcard3, load_dcard3};
  wire [1:0] lights = {player_win_light, dealer_win_light};
  wire [8:0] all_out = {loads, clear_cards, lights};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  // One full round from reset. p4/d4: scores at CHK; pf/df: final scores;
  // pd/bd: expected player / banker third-card draws; lat: edges from reset
  // release to lights; lt: expected {player, dealer} lights.
  task automatic round(input string tag,
                       input logic [3:0] p4, input logic [3:0] d4,
                       input logic [3:0] c3,
                       input logic [3:0] pf, input logic [3:0] df,
                       input bit pd, input bit bd,
                       input int lat, input logic [1:0] lt);
    logic [5:0] q[$];
    logic [5:0] exp_l;
    int e;
    bit got;
    pscore = p4;
    dscore = d4;
    pcard3 = c3;
    resetb = 1'b0;
    #3;
    chk({tag, " reset outputs"}, 32'(all_out), 32'd0);
    step();
    resetb = 1'b1;
    chk({tag, " idle outputs"}, 32'(all_out), 32'd0);

    q = '{L_P1, L_D1, L_P2, L_D2, 6'b0};
    if (pd) begin q.push_back(L_P3); q.push_back(6'b0); end
    if (bd) q.push_back(L_D3);
    q.push_back(6'b0);

    got = 1'b0;
    for (e = 1; e <= 20; e++) begin
      step();
      if (lights != 2'b00) begin got = 1'b1; break; end
      exp_l = (e <= q.size()) ? q[e-1] : 6'b0;
      chk({tag, " loads"}, 32'(loads), 32'(exp_l));
      if (e >= 2 && (e - 2) < q.size()) begin
        if (q[e-2] == L_P3) pscore = pf;
        if (q[e-2] == L_D3) dscore = df;
      end
    end
    chk({tag, " latency"}, got ? e : 0, lat);
    chk({tag, " lights"}, 32'(lights), 32'(lt));

`ifdef BACCARAT_AUTO_RESTART_EN
    for (int k = 1; k <= 4; k++) begin
      step();
      chk({tag, " hold"}, 32'(all_out), {23'd0, 6'b0, (k == 4), lt});
    end
    step();
    chk({tag, " restart"}, 32'(all_out), {23'd0, L_P1, 1'b0, 2'b00});
`else
    for (int k = 1; k <= 3; k++) begin
      step();
      chk({tag, " done hold"}, 32'(all_out), {23'd0, 6'b0, 1'b0, lt});
    end
`endif
  endtask

  initial begin
    //        tag              p4    d4    c3     pf    df   pd  bd lat lights
    round("natural",         4'd8, 4'd5, 4'd0,  4'd8, 4'd5, 0, 0, 7,  2'b10);
    round("banker natural",  4'd0, 4'd9, 4'd3,  4'd0, 4'd9, 0, 0, 7,  2'b01);
    round("both draw v0",    4'd3, 4'd4, 4'd13, 4'd3, 4'd4, 1, 0, 9,  2'b01);
    round("both draw v5",    4'd3, 4'd4, 4'd5,  4'd8, 4'd6, 1, 1, 10, 2'b10);
    round("banker3 v8",      4'd2, 4'd3, 4'd8,  4'd0, 4'd3, 1, 0, 9,  2'b01);
    round("banker3 v9",      4'd2, 4'd3, 4'd9,  4'd1, 4'd1, 1, 1, 10, 2'b11);
    round("banker3 face",    4'd0, 4'd3, 4'd10, 4'd0, 4'd5, 1, 1, 10, 2'b01);
    round("banker6 v7",      4'd1, 4'd6, 4'd7,  4'd8, 4'd9, 1, 1, 10, 2'b01);
    round("banker7 stands",  4'd5, 4'd7, 4'd6,  4'd1, 4'd7, 1, 0, 9,  2'b01);
    round("player stands",   4'd6, 4'd5, 4'd0,  4'd6, 4'd6, 0, 1, 8,  2'b11);
    round("both stand",      4'd7, 4'd6, 4'd0,  4'd7, 4'd6, 0, 0, 7,  2'b10);

    // Reset pulled in the middle of P2.
    pscore = 4'd3;
    dscore = 4'd4;
    pcard3 = 4'd5;
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    step();
    step();
    step();
    chk("midreset in P2", 32'(loads), 32'(L_P2));
    #2;
    resetb = 1'b0;
    #1;
    chk("midreset async", 32'(all_out), 32'd0);
    step();
    chk("midreset held", 32'(all_out), 32'd0);
    resetb = 1'b1;
    chk("midreset idle", 32'(all_out), 32'd0);
    step();
    chk("midreset restart P1", 32'(loads), 32'(L_P1));
    step();
    chk("midreset restart D1", 32'(loads), 32'(L_D1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
